// File: rtl/ldst_ctrl_pkg.sv
// ldst_pkg: shared opcodes, FSM state encoding and default parameters for ldst_ctrl
package ldst_pkg;
  localparam int IW_D = 16;
  localparam int FW_D = 6;
  localparam int NUM_REGS_D = 4;
  localparam int TIMEOUT_D = 15;
  localparam logic [3:0] OP_LOAD = 4'b0010;
  localparam logic [3:0] OP_STORE = 4'b0011;
  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_ADDR, S_MAR, S_ST_DRV, S_ST_WR, S_ST_WAIT,
    S_LD_WAIT, S_LD_CAP, S_LD_DRV, S_LD_WB, S_DONE, S_ERR
  } state_t;
endpackage

// File: rtl/ldst_ctrl_if.sv
// ldst_ctrl_if: request/memory handshake and datapath strobe bundle of the load/store sequencer
//   master: drives start, instr, mfc; observes busy/done/err and all strobes
//   slave : the sequencer side
interface ldst_ctrl_if import ldst_pkg::*; #(
  parameter int IW = IW_D,
  parameter int NUM_REGS = NUM_REGS_D
);
  logic start;
  logic [IW-1:0] instr;
  logic mfc;
  logic busy;
  logic done;
  logic err;
  logic mem_en;
  logic rw;
  logic mar_in;
  logic mdr_wr_en;
  logic mdr_rd_en;
  logic mdr_out;
  logic pc_inc;
  logic [NUM_REGS-1:0] rx_out;
  logic [NUM_REGS-1:0] rx_in;
  modport master (
    output start, instr, mfc,
    input busy, done, err, mem_en, rw, mar_in, mdr_wr_en, mdr_rd_en, mdr_out, pc_inc, rx_out, rx_in
  );
  modport slave (
    input start, instr, mfc,
    output busy, done, err, mem_en, rw, mar_in, mdr_wr_en, mdr_rd_en, mdr_out, pc_inc, rx_out, rx_in
  );
endinterface

// File: rtl/ldst_ctrl_reg_sel_dec.sv
// reg_sel_dec: register index to one-hot select (index 0 drives the MSB) plus in-range flag
//   i_idx   : register field
//   o_sel   : one-hot select, all zero when out of range
//   o_valid : index < NUM_REGS
module reg_sel_dec import ldst_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int FW = FW_D
) (
  input  logic [FW-1:0]       i_idx,
  output logic [NUM_REGS-1:0] o_sel,
  output logic                o_valid
);
  assign o_valid = 32'(i_idx) < 32'(NUM_REGS);
  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) o_sel[NUM_REGS-1-i] = (32'(i_idx) == i);
  end
endmodule

// File: rtl/ldst_ctrl.sv
// ldst_ctrl: Moore load/store sequencer driving register-file, MAR/MDR and memory strobes
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ldst_ctrl_if slave (start/instr/mfc in; busy/done/err and strobes out)
module ldst_ctrl import ldst_pkg::*; #(
  parameter int IW = IW_D,
  parameter int FW = FW_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input logic clk,
  input logic rst,
  ldst_ctrl_if.slave bus
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  state_t r_state, w_next;
  logic [IW-1:0] r_instr;
  logic [CW-1:0] r_cnt;
  logic [3:0] w_op;
  logic [NUM_REGS-1:0] w_sel1, w_sel2;
  logic w_v1, w_v2, w_legal, w_wait, w_tmo;
  assign w_op = r_instr[IW-1 -: 4];
  reg_sel_dec #(.NUM_REGS(NUM_REGS), .FW(FW)) u_dec1 (.i_idx(r_instr[IW-5 -: FW]), .o_sel(w_sel1), .o_valid(w_v1));
  reg_sel_dec #(.NUM_REGS(NUM_REGS), .FW(FW)) u_dec2 (.i_idx(r_instr[FW-1:0]), .o_sel(w_sel2), .o_valid(w_v2));
  assign w_legal = (w_op == OP_LOAD || w_op == OP_STORE) && w_v1 && w_v2;
  assign w_wait = (r_state == S_ST_WAIT) || (r_state == S_LD_WAIT);
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.start) r_instr <= bus.instr;
      // counter only runs while staying in a wait state, so it is zero on every entry
      r_cnt <= (w_wait && w_next == r_state) ? r_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = bus.start ? S_CHK : S_IDLE;
      S_CHK:     w_next = w_legal ? S_ADDR : S_ERR;
      S_ADDR:    w_next = S_MAR;
      S_MAR:     w_next = (w_op == OP_STORE) ? S_ST_DRV : S_LD_WAIT;
      S_ST_DRV:  w_next = S_ST_WR;
      S_ST_WR:   w_next = S_ST_WAIT;
      S_ST_WAIT: w_next = bus.mfc ? S_DONE : w_tmo ? S_ERR : S_ST_WAIT;
      S_LD_WAIT: w_next = bus.mfc ? S_LD_CAP : w_tmo ? S_ERR : S_LD_WAIT;
      S_LD_CAP:  w_next = S_LD_DRV;
      S_LD_DRV:  w_next = S_LD_WB;
      S_LD_WB:   w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end
  assign bus.busy = r_state != S_IDLE;
  assign bus.done = r_state == S_DONE;
  assign bus.err = r_state == S_ERR;
  assign bus.mem_en = w_wait || r_state == S_LD_CAP;
  assign bus.rw = r_state inside {S_LD_WAIT, S_LD_CAP, S_LD_DRV, S_LD_WB};
  assign bus.mar_in = r_state == S_MAR;
  assign bus.mdr_wr_en = r_state == S_ST_WR;
  assign bus.mdr_rd_en = r_state == S_LD_CAP;
  assign bus.mdr_out = r_state == S_LD_DRV || r_state == S_LD_WB;
  assign bus.pc_inc = r_state == S_ADDR;
  assign bus.rx_out = (r_state == S_ADDR || r_state == S_MAR) ? w_sel2 :
                      (r_state == S_ST_DRV || r_state == S_ST_WR) ? w_sel1 : '0;
  assign bus.rx_in = (r_state == S_LD_WB) ? w_sel1 : '0;
endmodule
